// File: rtl/timer_pkg.sv
// Shared types for the tick-driven countdown timer.
// The unit encoding matches the cfg_unit port. The state encoding is exported
// so the debug state port can be decoded by name.
package timer_pkg;

   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      UNIT_US   = 2'd0,
      UNIT_MS   = 2'd1,
      UNIT_SEC  = 2'd2,
      UNIT_RSVD = 2'd3
   } timer_unit_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } timer_state_e;

   // A start request is acceptable only with a real unit and a non-zero count.
   function automatic logic start_cfg_ok(input logic [1:0] unit, input logic any_count);
      return (unit != UNIT_RSVD) && any_count;
   endfunction

endpackage

// File: rtl/tick_countdown_timer_tick_unit_mux.sv
// Picks the tick pulse that matches the latched timer unit.
// This block is purely combinational. The reserved unit never produces a tick.
module tick_unit_mux
   import timer_pkg::*;
(
   input  timer_unit_e unit,
   input  logic        us_tick,
   input  logic        ms_tick,
   input  logic        sec_tick,
   output logic        sel_tick
);

   // Route exactly one of the tick inputs. Ticks of the other units are ignored.
   always_comb begin
      sel_tick = 1'b0;
      case (unit)
         UNIT_US:  sel_tick = us_tick;
         UNIT_MS:  sel_tick = ms_tick;
         UNIT_SEC: sel_tick = sec_tick;
         default:  sel_tick = 1'b0;
      endcase
   end

endmodule

// File: rtl/tick_countdown_timer.sv
// Programmable countdown timer driven by the us/ms/sec tick pulses of the
// tick generator in the same clk_200 domain.
// It supports one-shot and periodic (auto-reload) modes, a registered expire
// pulse, and a sticky irq.
//
// Request semantics: start, stop and irq_clr are single-cycle level requests.
// Each is sampled on every posedge of clk_200, with no ready/acknowledge path.
// - A request is acted on in the cycle it is high, and its effect is visible
//   on the registered outputs after that edge.
// - Priority order is stop, then a valid start, then the selected tick.
// - An invalid start reports start_err and otherwise has no effect.
module tick_countdown_timer
   import timer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk_200,
   input  logic             reset,
   input  logic             us_tick,
   input  logic             ms_tick,
   input  logic             sec_tick,
   input  logic [1:0]       cfg_unit,
   input  logic             cfg_periodic,
   input  logic [CNT_W-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   input  logic             irq_clr,
   output logic             busy,
   output logic [CNT_W-1:0] remaining,
   output logic             expire,
   output logic             irq,
   output logic             start_err,
   output timer_state_e     dbg_state
);

   timer_state_e     state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   timer_unit_e      unit_q, unit_d;
   logic             periodic_q, periodic_d;
   logic             expire_q, expire_d;
   logic             irq_q, irq_d;
   logic             start_err_q, start_err_d;

   logic             sel_tick;
   logic             start_ok;

   tick_unit_mux u_tick_unit_mux (
      .unit     (unit_q),
      .us_tick  (us_tick),
      .ms_tick  (ms_tick),
      .sec_tick (sec_tick),
      .sel_tick (sel_tick)
   );

   assign start_ok = start && start_cfg_ok(cfg_unit, |load_value);

   // Next-state logic: stop wins, then a valid (re)start, then tick-driven counting.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      reload_d    = reload_q;
      unit_d      = unit_q;
      periodic_d  = periodic_q;
      expire_d    = 1'b0;
      start_err_d = 1'b0;

      if (stop) begin
         // Abort leaves the count frozen so software can read how far it got.
         state_d = ST_IDLE;
      end else if (start_ok) begin
         // A restart replaces the run, even if this cycle carries the final tick.
         state_d     = ST_RUN;
         remaining_d = load_value;
         reload_d    = load_value;
         unit_d      = timer_unit_e'(cfg_unit);
         periodic_d  = cfg_periodic;
      end else begin
         start_err_d = start;
         if ((state_q == ST_RUN) && sel_tick) begin
            if (remaining_q == CNT_W'(1)) begin
               expire_d = 1'b1;
               if (periodic_q) begin
                  remaining_d = reload_q;
               end else begin
                  remaining_d = '0;
                  state_d     = ST_IDLE;
               end
            end else if (remaining_q != '0) begin
               remaining_d = remaining_q - CNT_W'(1);
            end
         end
      end

      // Set wins over clear, both for the expiry being decided now and for the
      // expire pulse currently on the output.
      irq_d = expire_d | expire_q | (irq_q & ~irq_clr);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_200) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         reload_q    <= '0;
         unit_q      <= UNIT_US;
         periodic_q  <= 1'b0;
         expire_q    <= 1'b0;
         irq_q       <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         reload_q    <= reload_d;
         unit_q      <= unit_d;
         periodic_q  <= periodic_d;
         expire_q    <= expire_d;
         irq_q       <= irq_d;
         start_err_q <= start_err_d;
      end
   end

   assign busy      = (state_q == ST_RUN);
   assign remaining = remaining_q;
   assign expire    = expire_q;
   assign irq       = irq_q;
   assign start_err = start_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed bench for tick_countdown_timer.
// The stimulus follows hand-computed sequences, and the expected values are
// written inline.
`timescale 1ns/1ps
module tb_tick_countdown_timer;
   import timer_pkg::*;

   localparam int CNT_W = 16;

   logic             clk_200 = 1'b0;
   logic             reset;
   logic             us_tick, ms_tick, sec_tick;
   logic [1:0]       cfg_unit;
   logic             cfg_periodic;
   logic [CNT_W-1:0] load_value;
   logic             start, stop, irq_clr;
   logic             busy;
   logic [CNT_W-1:0] remaining;
   logic             expire, irq, start_err;
   timer_state_e     dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   tick_countdown_timer #(.CNT_W(CNT_W)) dut (
      .clk_200      (clk_200),
      .reset        (reset),
      .us_tick      (us_tick),
      .ms_tick      (ms_tick),
      .sec_tick     (sec_tick),
      .cfg_unit     (cfg_unit),
      .cfg_periodic (cfg_periodic),
      .load_value   (load_value),
      .start        (start),
      .stop         (stop),
      .irq_clr      (irq_clr),
      .busy         (busy),
      .remaining    (remaining),
      .expire       (expire),
      .irq          (irq),
      .start_err    (start_err),
      .dbg_state    (dbg_state)
   );

   // Clock and reset
   always #2.5 clk_200 = ~clk_200;

   // Checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drivers
   task automatic clear_pulses();
      us_tick = 1'b0; ms_tick = 1'b0; sec_tick = 1'b0;
      start = 1'b0; stop = 1'b0; irq_clr = 1'b0; reset = 1'b0;
   endtask

   // One clock: inputs already set are sampled at the edge, checks happen 1ns later.
   task automatic step();
      @(posedge clk_200);
      #1;
      clear_pulses();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_start(input logic [1:0] unit, input logic per, input logic [CNT_W-1:0] val);
      cfg_unit = unit; cfg_periodic = per; load_value = val; start = 1'b1;
   endtask

   task automatic check_outs(input string tag, input logic b, input int rem,
                             input logic ex, input logic iq, input logic se);
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".remaining"}, 32'(remaining), rem);
      check({tag, ".expire"}, 32'(expire), 32'(ex));
      check({tag, ".irq"}, 32'(irq), 32'(iq));
      check({tag, ".start_err"}, 32'(start_err), 32'(se));
   endtask

   initial begin
      clear_pulses();
      cfg_unit = 2'd0; cfg_periodic = 1'b0; load_value = '0;
      reset = 1'b1;
      @(posedge clk_200); #1;
      reset = 1'b1;
      step();
      check_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      check("reset.state", 32'(dbg_state), 32'(ST_IDLE));

      // 1: one-shot, us, load 3, a tick every 4 cycles
      do_start(2'd0, 1'b0, 16'd3); step();
      check_outs("t1.start", 1'b1, 3, 1'b0, 1'b0, 1'b0);
      idle(3); us_tick = 1'b1; step();
      check("t1.tick1", 32'(remaining), 2);
      idle(3); us_tick = 1'b1; step();
      check("t1.tick2", 32'(remaining), 1);
      idle(3); us_tick = 1'b1; step();
      check_outs("t1.expire", 1'b0, 0, 1'b1, 1'b1, 1'b0);
      step();
      check_outs("t1.after", 1'b0, 0, 1'b0, 1'b1, 1'b0);
      us_tick = 1'b1; step();
      check("t1.idle_tick", 32'(remaining), 0);

      // 2: periodic, ms, load 2; us ticks are noise
      irq_clr = 1'b1; do_start(2'd1, 1'b1, 16'd2); step();
      check_outs("t2.start", 1'b1, 2, 1'b0, 1'b0, 1'b0);
      us_tick = 1'b1; step();
      check("t2.wrong_unit", 32'(remaining), 2);
      ms_tick = 1'b1; step();
      check("t2.tick1", 32'(remaining), 1);
      idle(2); ms_tick = 1'b1; step();
      check_outs("t2.exp1", 1'b1, 2, 1'b1, 1'b1, 1'b0);
      step();
      irq_clr = 1'b1; step();
      check_outs("t2.clr", 1'b1, 2, 1'b0, 1'b0, 1'b0);
      ms_tick = 1'b1; step();
      check("t2.tick3", 32'(remaining), 1);
      ms_tick = 1'b1; step();
      check_outs("t2.exp2", 1'b1, 2, 1'b1, 1'b1, 1'b0);
      stop = 1'b1; step();
      check_outs("t2.stop", 1'b0, 2, 1'b0, 1'b1, 1'b0);

      // 3: invalid starts in IDLE
      do_start(2'd0, 1'b0, 16'd0); step();
      check_outs("t3.zero", 1'b0, 2, 1'b0, 1'b1, 1'b1);
      step();
      check("t3.err_pulse", 32'(start_err), 0);
      do_start(2'd3, 1'b0, 16'd5); step();
      check_outs("t3.rsvd", 1'b0, 2, 1'b0, 1'b1, 1'b1);

      // 4: stop beats sec_tick and a valid start
      do_start(2'd2, 1'b0, 16'd5); step();
      check_outs("t4.start", 1'b1, 5, 1'b0, 1'b1, 1'b0);
      stop = 1'b1; sec_tick = 1'b1; do_start(2'd2, 1'b0, 16'd9); step();
      check_outs("t4.stop", 1'b0, 5, 1'b0, 1'b1, 1'b0);
      sec_tick = 1'b1; step();
      check("t4.idle_tick", 32'(remaining), 5);

      // 5: restart on the final tick, then invalid start mid-run, then set-wins irq
      irq_clr = 1'b1; do_start(2'd0, 1'b0, 16'd2); step();
      check("t5.irq_clr", 32'(irq), 0);
      us_tick = 1'b1; step();
      check("t5.rem1", 32'(remaining), 1);
      us_tick = 1'b1; do_start(2'd0, 1'b0, 16'd7); step();
      check_outs("t5.restart", 1'b1, 7, 1'b0, 1'b0, 1'b0);
      us_tick = 1'b1; do_start(2'd3, 1'b1, 16'd9); step();
      check_outs("t5.bad_start", 1'b1, 6, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         us_tick = 1'b1; step();
      end
      check("t5.rem_end", 32'(remaining), 1);
      us_tick = 1'b1; step();
      check_outs("t5.expire", 1'b0, 0, 1'b1, 1'b1, 1'b0);
      irq_clr = 1'b1; step();
      check("t5.set_wins", 32'(irq), 1);
      irq_clr = 1'b1; step();
      check("t5.clr_after", 32'(irq), 0);

      // 6: several ticks at once, wrong units, reset mid-run
      do_start(2'd1, 1'b1, 16'd1); step();
      ms_tick = 1'b1; step();
      check_outs("t6.exp", 1'b1, 1, 1'b1, 1'b1, 1'b0);
      do_start(2'd1, 1'b0, 16'd5); step();
      us_tick = 1'b1; ms_tick = 1'b1; sec_tick = 1'b1; step();
      check("t6.multi_tick", 32'(remaining), 4);
      us_tick = 1'b1; step();
      sec_tick = 1'b1; step();
      check_outs("t6.wrong_units", 1'b1, 4, 1'b0, 1'b1, 1'b0);
      reset = 1'b1; ms_tick = 1'b1; step();
      check_outs("t6.reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      check("t6.state", 32'(dbg_state), 32'(ST_IDLE));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
